mem_writer: RTL and testbench
=============================

MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 The module SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 rdy  in  1  global enable; low = pipeline pause.
REQ-005 req_valid  in  1  store request present.
REQ-006 req_addr  in  32  byte address of first byte.
REQ-007 req_data  in  32  store data, little-endian; byte i = req_data[8i+7:8i].
REQ-008 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
REQ-009 req_ready  out  1  high when a request can be accepted.
REQ-010 io_buffer_full  in  1  UART output buffer full.
REQ-011 mem_a  out  32  memory byte address.
REQ-012 mem_dout  out  8  memory write byte.
REQ-013 mem_wr  out  1  1 = write this cycle.
REQ-014 done  out  1  one-cycle pulse marking completion of a store.

Function
REQ-015 States SHALL be IDLE and WRITE, plus a 2-bit byte index idx and a 2-bit last-index register.
REQ-016 req_ready SHALL equal (state == IDLE).
REQ-017 Acceptance SHALL occur on an edge where rdy && req_valid && req_ready: latch addr, data, last index (0/1/3), set idx = 0, go to WRITE.
REQ-018 Outputs SHALL be registered: the first byte is driven in the cycle after acceptance (latency 1).
REQ-019 In WRITE, each rdy-high cycle without stall SHALL drive mem_a = base + idx (mod 2^32), mem_dout = byte idx, mem_wr = 1, then increment idx.
REQ-020 Misaligned base addresses SHALL be legal: bytes go to consecutive addresses, wrapping at 0xFFFFFFFF -> 0x00000000.
REQ-021 done SHALL be high in the same cycle the last byte is driven; the state SHALL return to IDLE on the following edge.
REQ-022 A store of N bytes SHALL occupy exactly N consecutive write cycles when unstalled; back-to-back stores SHALL have one IDLE cycle between them.
REQ-023 When rdy is low, the module SHALL hold state and idx, drive mem_wr = 0 and done = 0, and accept no request.
REQ-024 IO stall: if the latched address has addr[17:16] == 2'b11 and io_buffer_full is 1, the module SHALL drive mem_wr = 0 and hold idx until io_buffer_full falls.
REQ-025 In IDLE, or in any cycle with no byte write, mem_wr SHALL be 0, mem_dout SHALL be 0 and mem_a SHALL hold its last value.
REQ-026 req_valid during WRITE SHALL be ignored; the requester SHALL hold it until req_ready.

Reset
REQ-027 On rst, immediately and regardless of clk, the module SHALL reset state = IDLE, idx = 0, mem_a = 0, mem_dout = 0, mem_wr = 0 and done = 0.
REQ-028 A reset mid-store SHALL abandon the remaining bytes with no further writes; already-written bytes SHALL remain in memory.
REQ-029 After release, the first acceptance SHALL be possible on the first rdy-high edge.

Structure
REQ-030 Shared package SHALL hold: size encodings (SIZE_B/SIZE_H/SIZE_W), IO address-select constant (2'b11 on bits 17:16) and the state encoding.
REQ-031 The block SHALL have no sub-module; the byte-select mux is inline.

Verification
REQ-032 Word store, addr 0x00001000, data 0xDEADBEEF, rdy = 1 -> writes EF@1000, BE@1001, AD@1002, DE@1003 in cycles 1-4, done in cycle 4, req_ready high in cycle 5.
REQ-033 Half store, addr 0x00000FFF, data 0x00001234 -> writes 34@0FFF, 12@1000, done with 2nd byte; word at 0xFFFFFFFE -> wrap to 0x00000000 and 0x00000001.
REQ-034 Word store with rdy low for 2 cycles after byte 1 -> mem_wr = 0 for those 2 cycles, no byte repeated or skipped, done delayed by 2 cycles.
REQ-035 Byte store, addr 0x00030000, data 0x41, io_buffer_full = 1 for 3 cycles -> mem_wr = 0 for 3 cycles, then a single write 0x41, then done.
REQ-036 rst asserted between edges during byte 2 of a word store -> mem_wr = 0 immediately, no further writes, req_ready = 1 after release.
REQ-037 Back-to-back byte stores (addr 0x10, then 0x20) with req_valid held -> writes 1 cycle apart with one IDLE gap, two done pulses.

Source files
------------

// File: rtl/mem_writer_pkg.sv
// Shared constants and types for the byte-serial store writer.
// Size encodings, IO address select and FSM state encoding.
package mem_writer_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [1:0] IO_SEL = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  function automatic logic [1:0] last_idx(input logic [1:0] size);
    logic [1:0] r;
    case (size)
      SIZE_B:  r = 2'd0;
      SIZE_H:  r = 2'd1;
      SIZE_W:  r = 2'd3;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_writer.sv
// Byte-serial store writer: splits byte/half/word stores into
// single-byte memory writes, with pause and UART-full stall.
module mem_writer
  import mem_writer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        req_ready,
  input  logic        io_buffer_full,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  output logic        done
);

  state_e      state_q;
  state_e      state_d;
  logic [1:0]  idx_q;
  logic [1:0]  last_q;
  logic [31:0] base_q;
  logic [31:0] data_q;
  logic        fin_q;

  logic        accept;
  logic        active;
  logic        stall;
  logic        issue;
  logic        last_byte;
  logic [31:0] cur_base;
  logic [31:0] cur_data;
  logic [1:0]  cur_idx;
  logic [1:0]  cur_last;
  logic [7:0]  byte_sel;

  assign req_ready = (state_q == ST_IDLE);

  // The accepting edge already emits byte 0, so the
  // request fields are taken straight from the inputs.
  always_comb begin
    accept    = rdy && req_valid && req_ready;
    cur_base  = accept ? req_addr : base_q;
    cur_data  = accept ? req_data : data_q;
    cur_idx   = accept ? 2'd0 : idx_q;
    cur_last  = accept ? last_idx(req_size) : last_q;
    active    = accept || (state_q == ST_WRITE && !fin_q);
    stall     = (cur_base[17:16] == IO_SEL) && io_buffer_full;
    issue     = rdy && active && !stall;
    last_byte = (cur_idx == cur_last);
  end

  always_comb begin
    byte_sel = 8'h00;
    unique case (cur_idx)
      2'd0: byte_sel = cur_data[7:0];
      2'd1: byte_sel = cur_data[15:8];
      2'd2: byte_sel = cur_data[23:16];
      2'd3: byte_sel = cur_data[31:24];
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_WRITE;
      ST_WRITE: if (rdy && fin_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= 2'd0;
      last_q   <= 2'd0;
      base_q   <= 32'h0;
      data_q   <= 32'h0;
      fin_q    <= 1'b0;
      mem_a    <= 32'h0;
      mem_dout <= 8'h00;
      mem_wr   <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_wr   <= issue;
      done     <= issue && last_byte;
      mem_dout <= issue ? byte_sel : 8'h00;
      if (issue) mem_a <= cur_base + {30'h0, cur_idx};
      if (accept) begin
        base_q <= req_addr;
        data_q <= req_data;
        last_q <= last_idx(req_size);
        idx_q  <= 2'd0;
        fin_q  <= 1'b0;
      end
      if (issue) begin
        idx_q <= cur_idx + 2'd1;
        fin_q <= last_byte;
      end
    end
  end

endmodule

// File: tb/tb_mem_writer.sv
// Directed bench for mem_writer: hand-computed byte streams,
// pause, IO stall, address wrap, mid-store reset, back-to-back.
module tb_mem_writer;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        req_ready;
  logic        io_buffer_full;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        done;

  int n_cmp;
  int n_err;

  mem_writer dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_size       (req_size),
    .req_ready      (req_ready),
    .io_buffer_full (io_buffer_full),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(
    input string       tag,
    input logic        wr,
    input logic        dn,
    input logic [31:0] a,
    input logic [7:0]  d,
    input logic        rr
  );
    logic [42:0] obs;
    logic [42:0] exp;
    obs = {mem_wr, done, mem_a, mem_dout, req_ready};
    exp = {wr, dn, a, d, rr};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: wr/done/a/dout/ready got %b/%b/%h/%h/%b want %b/%b/%h/%h/%b",
             tag, mem_wr, done, mem_a, mem_dout, req_ready,
             wr, dn, a, d, rr);
    end
  endtask

  task automatic send(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [1:0]  s
  );
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    rdy = 1'b0;
    req_valid = 1'b0;
    req_addr = 32'h0;
    req_data = 32'h0;
    req_size = 2'd0;
    io_buffer_full = 1'b0;

    #1 rst = 1'b1;
    #2;
    expect_out("reset", 0, 0, 32'h0, 8'h00, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy = 1'b1;

    // word store
    send(32'h0000_1000, 32'hDEAD_BEEF, 2'd2);
    step();
    req_valid = 1'b0;
    expect_out("w_b0", 1, 0, 32'h0000_1000, 8'hEF, 0);
    step();
    expect_out("w_b1", 1, 0, 32'h0000_1001, 8'hBE, 0);
    step();
    expect_out("w_b2", 1, 0, 32'h0000_1002, 8'hAD, 0);
    step();
    expect_out("w_b3", 1, 1, 32'h0000_1003, 8'hDE, 0);
    step();
    expect_out("w_idle", 0, 0, 32'h0000_1003, 8'h00, 1);

    // half store across 0x1000
    send(32'h0000_0FFF, 32'h0000_1234, 2'd1);
    step();
    req_valid = 1'b0;
    expect_out("h_b0", 1, 0, 32'h0000_0FFF, 8'h34, 0);
    step();
    expect_out("h_b1", 1, 1, 32'h0000_1000, 8'h12, 0);
    step();
    expect_out("h_idle", 0, 0, 32'h0000_1000, 8'h00, 1);

    // word wrapping at top of address space
    send(32'hFFFF_FFFE, 32'h4433_2211, 2'd2);
    step();
    req_valid = 1'b0;
    expect_out("wrap_b0", 1, 0, 32'hFFFF_FFFE, 8'h11, 0);
    step();
    expect_out("wrap_b1", 1, 0, 32'hFFFF_FFFF, 8'h22, 0);
    step();
    expect_out("wrap_b2", 1, 0, 32'h0000_0000, 8'h33, 0);
    step();
    expect_out("wrap_b3", 1, 1, 32'h0000_0001, 8'h44, 0);
    step();
    expect_out("wrap_idle", 0, 0, 32'h0000_0001, 8'h00, 1);

    // pause for two cycles after byte 0
    send(32'h0000_2000, 32'h8765_4321, 2'd3);
    step();
    req_valid = 1'b0;
    expect_out("p_b0", 1, 0, 32'h0000_2000, 8'h21, 0);
    rdy = 1'b0;
    step();
    expect_out("p_hold1", 0, 0, 32'h0000_2000, 8'h00, 0);
    step();
    expect_out("p_hold2", 0, 0, 32'h0000_2000, 8'h00, 0);
    rdy = 1'b1;
    step();
    expect_out("p_b1", 1, 0, 32'h0000_2001, 8'h43, 0);
    step();
    expect_out("p_b2", 1, 0, 32'h0000_2002, 8'h65, 0);
    step();
    expect_out("p_b3", 1, 1, 32'h0000_2003, 8'h87, 0);
    step();
    expect_out("p_idle", 0, 0, 32'h0000_2003, 8'h00, 1);

    // IO stall: UART full for three cycles
    io_buffer_full = 1'b1;
    send(32'h0003_0000, 32'h0000_0041, 2'd0);
    step();
    req_valid = 1'b0;
    expect_out("io_st1", 0, 0, 32'h0000_2003, 8'h00, 0);
    step();
    expect_out("io_st2", 0, 0, 32'h0000_2003, 8'h00, 0);
    step();
    expect_out("io_st3", 0, 0, 32'h0000_2003, 8'h00, 0);
    io_buffer_full = 1'b0;
    step();
    expect_out("io_wr", 1, 1, 32'h0003_0000, 8'h41, 0);
    step();
    expect_out("io_idle", 0, 0, 32'h0003_0000, 8'h00, 1);

    // non-IO region ignores a full UART
    io_buffer_full = 1'b1;
    send(32'h0002_0000, 32'h0000_005A, 2'd0);
    step();
    req_valid = 1'b0;
    expect_out("nio_wr", 1, 1, 32'h0002_0000, 8'h5A, 0);
    io_buffer_full = 1'b0;
    step();
    expect_out("nio_idle", 0, 0, 32'h0002_0000, 8'h00, 1);

    // reset between edges during byte 1 of a word
    send(32'h0000_3000, 32'hCAFE_F00D, 2'd2);
    step();
    req_valid = 1'b0;
    expect_out("r_b0", 1, 0, 32'h0000_3000, 8'h0D, 0);
    step();
    expect_out("r_b1", 1, 0, 32'h0000_3001, 8'hF0, 0);
    #2 rst = 1'b1;
    #1;
    expect_out("r_async", 0, 0, 32'h0, 8'h00, 1);
    step();
    rst = 1'b0;
    step();
    expect_out("r_after", 0, 0, 32'h0, 8'h00, 1);

    // back-to-back byte stores, req_valid held
    send(32'h0000_0010, 32'h0000_0011, 2'd0);
    step();
    expect_out("bb_1", 1, 1, 32'h0000_0010, 8'h11, 0);
    req_addr = 32'h0000_0020;
    req_data = 32'h0000_0022;
    step();
    expect_out("bb_gap", 0, 0, 32'h0000_0010, 8'h00, 1);
    step();
    req_valid = 1'b0;
    expect_out("bb_2", 1, 1, 32'h0000_0020, 8'h22, 0);
    step();
    expect_out("bb_idle", 0, 0, 32'h0000_0020, 8'h00, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
